// File: rtl/uart_cmd_pkg.sv
// Shared ASCII command/response constants and MODE encodings for the UART command hub.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_BASE = 8'h31;  // '1' toggles led[0]
    localparam logic [7:0] CMD_CLR  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_SET  = 8'h73;  // 's'
    localparam logic [7:0] ACK      = 8'h2B;  // '+'
    localparam logic [7:0] NAK      = 8'h3F;  // '?'

    localparam int MODE_LOOP = 0;
    localparam int MODE_ACK  = 1;

endpackage

// File: rtl/byte_fifo.sv
// Per-channel rx byte buffer: first-word fall-through head, push ignored when full unless popped.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        wr_en, rd_en;

    // A pop frees the slot the push is about to fill, so push-on-full is fine then.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_cmd_hub.sv
// Multi-channel UART command hub: per-channel rx FIFOs, round-robin pop, LED command
// decode and a per-channel reply (loopback or ACK/NAK), plus a heartbeat LED.
module uart_cmd_hub
    import uart_cmd_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int NUM_LEDS   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = 0,
    parameter int HB_BITS    = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   rx_valid,
    input  logic [8*CHANNELS-1:0] rx_data,
    input  logic [CHANNELS-1:0]   tx_ready,
    output logic [CHANNELS-1:0]   tx_send,
    output logic [8*CHANNELS-1:0] tx_data,
    output logic [NUM_LEDS:0]     led,
    output logic [CHANNELS-1:0]   overflow
);
    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]       fifo_full, fifo_empty, elig, pop;
    logic [CHANNELS-1:0][7:0]  head;
    logic [PTR_W-1:0]          rr_ptr, gnt_idx, cand, sel_idx;
    logic                      gnt_vld, sel_vld, recognised;
    logic [7:0]                sel_byte, reply;
    logic [NUM_LEDS-1:0]       cmd_led, cmd_led_nxt;
    logic [HB_BITS-1:0]        hb_cnt;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (rx_valid[g]),
            .din   (rx_data[8*g +: 8]),
            .pop   (pop[g]),
            .head  (head[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    assign elig = ~fifo_empty & tx_ready;

    // Scan from the highest offset down so the candidate nearest the pointer wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(rr_ptr) + k) % CHANNELS);
            if (elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int c = 0; c < CHANNELS; c++)
            pop[c] = gnt_vld && (gnt_idx == PTR_W'(c));
    end

    always_comb begin
        cmd_led_nxt = cmd_led;
        recognised  = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (sel_byte == CMD_BASE + 8'(i)) begin
                cmd_led_nxt[i] = ~cmd_led[i];
                recognised     = 1'b1;
            end
        end
        if (sel_byte == CMD_CLR) begin
            cmd_led_nxt = '0;
            recognised  = 1'b1;
        end else if (sel_byte == CMD_SET) begin
            cmd_led_nxt = '1;
            recognised  = 1'b1;
        end
    end

    assign reply = (MODE == MODE_ACK) ? (recognised ? ACK : NAK) : sel_byte;
    assign led   = {hb_cnt[HB_BITS-1], cmd_led};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            sel_vld  <= 1'b0;
            sel_idx  <= '0;
            sel_byte <= '0;
            tx_send  <= '0;
            tx_data  <= '0;
            cmd_led  <= '0;
            hb_cnt   <= '0;
            overflow <= '0;
        end else begin
            hb_cnt   <= hb_cnt + 1'b1;
            overflow <= overflow | (rx_valid & fifo_full & ~pop);
            sel_vld  <= gnt_vld;
            if (gnt_vld) begin
                sel_idx  <= gnt_idx;
                sel_byte <= head[gnt_idx];
                rr_ptr   <= (gnt_idx == PTR_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
            end
            tx_send <= '0;
            if (sel_vld) begin
                cmd_led <= cmd_led_nxt;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (sel_idx == PTR_W'(c)) begin
                        tx_send[c]         <= 1'b1;
                        tx_data[8*c +: 8]  <= reply;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_hub.sv
// Scoreboard bench: a loopback and an ACK-mode hub share stimulus and are checked
// against a queue-based behavioural model of the channel FIFOs and arbiter.
module tb_uart_cmd_hub;
    localparam int CH = 2;
    localparam int NL = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     rx_valid = '0;
    logic [8*CH-1:0]   rx_data = '0;
    logic [CH-1:0]     tx_ready = '1;
    logic [CH-1:0]     tx_send0, tx_send1, ovf0, ovf1;
    logic [8*CH-1:0]   tx_data0, tx_data1;
    logic [NL:0]       led0, led1;

    always #5 clk = ~clk;

    uart_cmd_hub #(.CHANNELS(CH), .NUM_LEDS(NL), .FIFO_DEPTH(DEPTH), .MODE(0), .HB_BITS(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
        .tx_send(tx_send0), .tx_data(tx_data0), .led(led0), .overflow(ovf0));

    uart_cmd_hub #(.CHANNELS(CH), .NUM_LEDS(NL), .FIFO_DEPTH(DEPTH), .MODE(1), .HB_BITS(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
        .tx_send(tx_send1), .tx_data(tx_data1), .led(led1), .overflow(ovf1));

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int ch; logic [7:0] b; bit rec; } exp_t;
    exp_t        exp_q[$];
    logic [7:0]  mq [CH][$];
    int          mptr = 0;
    bit          pv = 0;
    int          pch = 0;
    logic [7:0]  pb = '0;
    logic [NL-1:0] mled = '0;
    logic [CH-1:0] movf = '0;
    logic [3:0]  mhb = '0;

    function automatic bit is_rec(input logic [7:0] b);
        return (b >= 8'h31 && b <= 8'h30 + 8'(NL)) || b == 8'h63 || b == 8'h73;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) mq[c].delete();
        exp_q.delete();
        mptr = 0; pv = 0; mled = '0; movf = '0; mhb = '0;
    endtask

    task automatic model_step();
        bit found;
        bit [CH-1:0] popped;
        exp_t e;
        if (pv) begin
            e.ch = pch; e.b = pb; e.rec = is_rec(pb);
            exp_q.push_back(e);
            if (pb == 8'h63) mled = '0;
            else if (pb == 8'h73) mled = '1;
            else if (pb >= 8'h31 && pb <= 8'h30 + 8'(NL)) mled[pb - 8'h31] = ~mled[pb - 8'h31];
        end
        pv = 0;
        found = 0;
        popped = '0;
        for (int k = 0; k < CH; k++) begin
            int c;
            c = (mptr + k) % CH;
            if (!found && mq[c].size() > 0 && tx_ready[c]) begin
                found = 1;
                pv = 1; pch = c; pb = mq[c].pop_front();
                popped[c] = 1'b1;
                mptr = (c + 1) % CH;
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (rx_valid[c]) begin
                if (mq[c].size() < DEPTH) mq[c].push_back(rx_data[8*c +: 8]);
                else movf[c] = 1'b1;
            end
        end
        mhb = mhb + 4'd1;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            exp_t e;
            bit have;
            logic [CH-1:0] exp_send;
            @(negedge clk);
            if (rst_n) begin
                have = 0;
                exp_send = '0;
                if (exp_q.size() > 0 || tx_send0 != '0 || tx_send1 != '0) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        exp_send[e.ch] = 1'b1;
                        have = 1;
                    end
                end
                check("tx_send_loop", 32'(tx_send0), 32'(exp_send));
                check("tx_send_ack", 32'(tx_send1), 32'(exp_send));
                if (have) begin
                    check("tx_data_loop", 32'(tx_data0[8*e.ch +: 8]), 32'(e.b));
                    check("tx_data_ack", 32'(tx_data1[8*e.ch +: 8]), e.rec ? 32'h2B : 32'h3F);
                end
                check("led_loop", 32'(led0), 32'({mhb[3], mled}));
                check("led_ack", 32'(led1), 32'({mhb[3], mled}));
                check("overflow_loop", 32'(ovf0), 32'(movf));
                check("overflow_ack", 32'(ovf1), 32'(movf));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [CH-1:0] v, input logic [8*CH-1:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = '0;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_send0"}, 32'(tx_send0), 0);
        check({tag, "_send1"}, 32'(tx_send1), 0);
        check({tag, "_data0"}, 32'(tx_data0), 0);
        check({tag, "_data1"}, 32'(tx_data1), 0);
        check({tag, "_led0"}, 32'(led0), 0);
        check({tag, "_led1"}, 32'(led1), 0);
        check({tag, "_ovf0"}, 32'(ovf0), 0);
        check({tag, "_ovf1"}, 32'(ovf1), 0);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] pick [8];
        pick = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h63, 8'h73, 8'h41};
        if ($urandom_range(0, 4) == 0) return 8'($urandom);
        return pick[$urandom_range(0, 7)];
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        #1 check_cleared("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // toggle led[1] on and off via ch0
        drive(2'b01, {8'h00, 8'h32}); idle(4);
        drive(2'b01, {8'h00, 8'h32}); idle(4);
        // ch1: unknown, set-all, clear-all
        drive(2'b10, {8'h35, 8'h00}); idle(4);
        drive(2'b10, {8'h73, 8'h00}); idle(4);
        drive(2'b10, {8'h63, 8'h00}); idle(4);
        // simultaneous arrivals
        drive(2'b11, {8'h33, 8'h31}); idle(5);
        // ch0 stalled while five bytes arrive; ch1 keeps flowing
        tx_ready = 2'b10;
        drive(2'b01, {8'h00, 8'h31});
        drive(2'b11, {8'h34, 8'h32});
        drive(2'b01, {8'h00, 8'h33});
        drive(2'b11, {8'h73, 8'h34});
        drive(2'b01, {8'h00, 8'h35});
        idle(4);
        tx_ready = 2'b11;
        idle(10);

        // randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                rx_valid[c] = ($urandom_range(0, 2) == 0);
                rx_data[8*c +: 8] = rand_byte();
                tx_ready[c] = ($urandom_range(0, 4) != 0);
            end
        end
        tx_ready = '1;
        idle(20);

        // reset with bytes buffered and LEDs lit
        drive(2'b10, {8'h73, 8'h00}); idle(4);
        tx_ready = 2'b10;
        drive(2'b01, {8'h00, 8'h31});
        drive(2'b01, {8'h00, 8'h32});
        drive(2'b01, {8'h00, 8'h33});
        idle(2);
        #2 rst_n = 1'b0;
        #1 check_cleared("async_rst");
        tx_ready = '1;
        idle(3);
        #2 rst_n = 1'b1;
        idle(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_hub.md
Name: uart_cmd_hub

Overview:
- Multi-channel successor to the single-character LED-toggle loopback top.
- Sits between CHANNELS existing uart instances (rx valid/data in, send/data out) and the board LEDs.
- Each channel buffers received bytes in a small FIFO.
- A round-robin arbiter pops one byte per cycle from any channel. The byte is decoded as an LED command and answered on the same channel, either as raw loopback or as an ACK/NAK character, selected by MODE.

Parameters:
- CHANNELS, 2, number of uart channels (1..8)
- NUM_LEDS, 4, number of command-controlled LEDs (1..9)
- FIFO_DEPTH, 4, per-channel rx FIFO depth in bytes; power of two, >=2
- MODE, 0, 0 = loopback (reply byte equals received byte); 1 = ack (reply 8'h2B '+' if recognised, 8'h3F '?' otherwise)
- HB_BITS, 24, heartbeat counter width; MSB drives led[NUM_LEDS]

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  CHANNELS  one-cycle byte-received strobe per channel
- rx_data  in  8*CHANNELS  received byte; channel i in bits [8i+7:8i]
- tx_ready  in  CHANNELS  channel transmitter idle, able to accept send
- tx_send  out  CHANNELS  one-cycle transmit strobe per channel
- tx_data  out  8*CHANNELS  byte to transmit; valid when tx_send high, held otherwise
- led  out  NUM_LEDS+1  [NUM_LEDS-1:0] command LEDs, [NUM_LEDS] heartbeat
- overflow  out  CHANNELS  sticky per-channel FIFO overflow flag

Behaviour:
- Reset (async assert, sync release) clears the following: all FIFOs empty, tx_send=0, tx_data=0, led=0, overflow=0, heartbeat counter=0, round-robin pointer=0.
- Heartbeat: counter increments every cycle and wraps. led[NUM_LEDS] = counter MSB.
- FIFO write:
  - rx_valid[i] pushes rx_data[i] at the rising edge.
  - If FIFO i is full and not popped in the same cycle, the byte is dropped and overflow[i] is set. overflow[i] stays set until reset.
  - Simultaneous push and pop on a full FIFO is legal and loses nothing.
- Eligibility: channel i is eligible when its FIFO is non-empty and tx_ready[i]=1.
- Arbiter:
  - Each cycle it grants at most one eligible channel, searching upward from the pointer and wrapping.
  - On a grant it pops the head byte and sets pointer = granted index + 1, wrapping at CHANNELS.
  - With no grant, the pointer holds.
- Decode of the popped byte b:
  - 8'h31..(8'h30+NUM_LEDS): toggle led[b-8'h31].
  - 8'h63 'c': all command LEDs cleared.
  - 8'h73 's': all command LEDs set.
  - Anything else: no LED change, unrecognised.
- Response:
  - In the cycle after the grant, tx_send[g]=1 for exactly one cycle, and tx_data[g] = b (MODE 0) or the '+'/'?' character (MODE 1).
  - LED updates happen on the same edge as the response.
- Latency: rx_valid at edge t means the byte is visible in the FIFO after edge t. The earliest grant is in the cycle after t. tx_send and the LED change appear after edge t+2.
- Throughput: one byte per cycle aggregate. With all channels continuously eligible, each channel is served once every CHANNELS cycles.
- tx_ready low holds a channel's bytes in its FIFO. This must not block other channels.
- Reset mid-operation: all buffered bytes are discarded, and any pending tx_send is suppressed.

Decomposition:
- Package uart_cmd_pkg holds the ASCII constants (CMD_BASE 8'h31, CMD_CLR 8'h63, CMD_SET 8'h73, ACK 8'h2B, NAK 8'h3F) and the MODE encodings.
- Sub-module byte_fifo (parameter DEPTH):
  - synchronous 8-bit FIFO with push/pop/full/empty/head; head is first-word fall-through
  - instantiated CHANNELS times in a generate loop
- Arbiter, decoder and LED register stay in the top.

Test Plan:
- MODE 0, CHANNELS=2: ch0 receives 8'h32 → tx_send[0] pulse with tx_data[7:0]=8'h32 two cycles later; led[1] goes 0→1; a second 8'h32 returns it to 0.
- MODE 1: ch1 receives 8'h35 with NUM_LEDS=4 → no LED change, tx_data[15:8]=8'h3F. Then 8'h73 → led[3:0]=4'hF and reply 8'h2B. Then 8'h63 → led[3:0]=0.
- Simultaneous rx_valid on both channels (8'h31 on ch0, 8'h33 on ch1) → grants on consecutive cycles in round-robin order; led[0] and led[2] both set; each reply appears only on its own channel.
- tx_ready[0]=0 while FIFO_DEPTH+1=5 bytes arrive on ch0 → overflow[0]=1, 4 bytes retained; ch1 traffic is serviced meanwhile. After tx_ready[0]=1, exactly 4 replies are sent in order.
- Heartbeat with HB_BITS=4 → led[4] toggles every 8 cycles from reset.
- rst_n asserted with 3 bytes buffered → outputs clear asynchronously; after release, no tx_send occurs, and overflow and led read 0.
